// File: rtl/text_display_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_display_sequencer_pkg
// Shared state encoding and default sizing for the text display sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
package text_display_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int DEF_NUM_MSGS   = 4;
  localparam int DEF_GAP_CYCLES = 3;
  // Gap counter width covers the largest legal gap length (255).
  localparam int GAP_CNT_W      = 8;

endpackage

`default_nettype wire

// File: rtl/text_display_sequencer_gap_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gap_timer
// Loadable down-counter with a zero flag; timer_end of the blank interval.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gap_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over tick; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/text_display_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_display_sequencer
// Steps through NUM_MSGS messages, enabling an external display timer while
// each is shown and inserting a blank gap between messages.
// Revision: 1.0
// ---------------------------------------------------------------------------
module text_display_sequencer
  import text_display_sequencer_pkg::*;
#(
  parameter int NUM_MSGS   = DEF_NUM_MSGS,
  parameter int IDX_W      = 4,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             repeat_en_i,
  input  logic             timer_end_i,
  output logic             timer_enable_o,
  output logic [IDX_W-1:0] msg_index_o,
  output logic             display_on_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_MSGS - 1);
  // The gap lasts while the counter walks GAP_CYCLES-1 .. 0.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rep_q, rep_d;
  logic             timer_enable_q, busy_q, done_q;
  logic             gap_load, gap_tick, gap_zero;

  gap_timer #(
    .CNT_W (GAP_CNT_W)
  ) u_gap_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .tick_i     (gap_tick),
    .zero_o     (gap_zero)
  );

  // Next-state logic; abort beats timer_end and start in every busy state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    gap_load = 1'b0;
    gap_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_SHOW;
          idx_d   = '0;
          rep_d   = repeat_en_i;
        end
      end
      ST_SHOW: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (timer_end_i) begin
          if (idx_q == LAST_IDX) begin
            if (rep_q) begin
              state_d  = ST_GAP;
              idx_d    = '0;
              gap_load = 1'b1;
            end else begin
              state_d = ST_FINISH;
            end
          end else begin
            state_d  = ST_GAP;
            idx_d    = idx_q + IDX_W'(1);
            gap_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (gap_zero) begin
          state_d = ST_SHOW;
        end else begin
          gap_tick = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (abort_i) begin
          idx_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      rep_q          <= 1'b0;
      timer_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      rep_q          <= rep_d;
      timer_enable_q <= (state_d == ST_SHOW);
      busy_q         <= (state_d != ST_IDLE);
      done_q         <= (state_d == ST_FINISH);
    end
  end

  assign timer_enable_o = timer_enable_q;
  assign display_on_o   = timer_enable_q;
  assign msg_index_o    = idx_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_text_display_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_text_display_sequencer
// Self-checking bench for text_display_sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_text_display_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0, rep = 1'b0, tend = 1'b0;
  logic       te_o, disp_o, busy_o, done_o;
  logic [3:0] idx_o;

  logic       start1 = 1'b0, tend1 = 1'b0, abort1 = 1'b0, rep1 = 1'b0;
  logic       te1_o, disp1_o, busy1_o, done1_o;
  logic [3:0] idx1_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  text_display_sequencer #(.NUM_MSGS(4), .IDX_W(4), .GAP_CYCLES(3)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .repeat_en_i(rep), .timer_end_i(tend), .timer_enable_o(te_o),
    .msg_index_o(idx_o), .display_on_o(disp_o), .busy_o(busy_o), .done_o(done_o)
  );

  text_display_sequencer #(.NUM_MSGS(1), .IDX_W(4), .GAP_CYCLES(3)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .abort_i(abort1),
    .repeat_en_i(rep1), .timer_end_i(tend1), .timer_enable_o(te1_o),
    .msg_index_o(idx1_o), .display_on_o(disp1_o), .busy_o(busy1_o), .done_o(done1_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, st, ab, rp, tn;
    logic te;
    int   idx;
    logic busy, done;
  } vec_t;

  vec_t vecs[19];

  // Scenario observations
  int w_idx[$];
  int w_len[$];
  int g_len[$];
  int done_cnt, done_cyc, fall_cyc, first_te;
  bit busy_low_seen, timed_out;

  // Start a run and act as the external display timer: timer_end is pulsed
  // so that it is sampled on the 10th edge after timer_enable rises.
  task automatic run_scn(input bit r, input int stop_windows, input int max_cyc);
    int  cyc, rise, run_hi, run_lo;
    bit  prev_te;
    w_idx.delete(); w_len.delete(); g_len.delete();
    done_cnt = 0; done_cyc = -1; fall_cyc = -1; busy_low_seen = 0; timed_out = 1;
    cyc = 0; rise = -100; run_hi = 0; run_lo = 0; prev_te = 0;
    @(negedge clk); start = 1'b1; rep = r;
    @(posedge clk); #1;
    first_te = int'(te_o);
    for (int k = 0; k < max_cyc; k++) begin
      if (k == 1) start = 1'b0;
      if (te_o) begin
        if (!prev_te) begin
          if (w_idx.size() > 0) g_len.push_back(run_lo);
          w_idx.push_back(int'(idx_o));
          rise = cyc;
          run_lo = 0;
        end
        run_hi++;
      end else begin
        if (prev_te) begin
          w_len.push_back(run_hi);
          run_hi = 0;
        end
        if (busy_o) run_lo++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!busy_o) begin
        busy_low_seen = 1;
        if (fall_cyc < 0) fall_cyc = cyc;
      end
      prev_te = te_o;
      if (!r && !busy_o) begin timed_out = 0; break; end
      if (r && w_idx.size() >= stop_windows) begin timed_out = 0; break; end
      @(negedge clk);
      start = 1'b0;
      tend  = te_o && (cyc + 1 == rise + 10);
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    tend = 1'b0; start = 1'b0;
  endtask

  initial begin
    int exp_idx4[4];
    int exp_idx6[6];
    exp_idx4 = '{0, 1, 2, 3};
    exp_idx6 = '{0, 1, 2, 3, 0, 1};

    //            rst st ab rp tn | te idx busy done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);

    // Cycle-by-cycle vectors: reset, ignored inputs, gap length, abort, reset mid-gap
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; start = vecs[i].st; abort = vecs[i].ab;
      rep = vecs[i].rp; tend = vecs[i].tn;
      @(posedge clk); #1;
      chk($sformatf("v%0d.timer_enable", i), int'(te_o), int'(vecs[i].te));
      chk($sformatf("v%0d.display_on", i), int'(disp_o), int'(vecs[i].te));
      chk($sformatf("v%0d.msg_index", i), int'(idx_o), vecs[i].idx);
      chk($sformatf("v%0d.busy", i), int'(busy_o), int'(vecs[i].busy));
      chk($sformatf("v%0d.done", i), int'(done_o), int'(vecs[i].done));
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0; rep = 1'b0; tend = 1'b0;
    @(negedge clk);

    // Full non-repeat run
    run_scn(1'b0, 0, 200);
    chk("run.timeout", int'(timed_out), 0);
    chk("run.start_latency", first_te, 1);
    chk("run.windows", w_idx.size(), 4);
    for (int i = 0; i < 4 && i < w_idx.size(); i++)
      chk($sformatf("run.idx%0d", i), w_idx[i], exp_idx4[i]);
    chk("run.win_lens", w_len.size(), 4);
    foreach (w_len[i]) chk($sformatf("run.win_len%0d", i), w_len[i], 10);
    chk("run.gaps", g_len.size(), 3);
    foreach (g_len[i]) chk($sformatf("run.gap_len%0d", i), g_len[i], 3);
    chk("run.done_count", done_cnt, 1);
    chk("run.busy_fall_after_done", fall_cyc, done_cyc + 1);
    chk("run.final_idx", int'(idx_o), 3);

    // Repeat run: wraps to message 0, never completes
    run_scn(1'b1, 6, 200);
    chk("rep.timeout", int'(timed_out), 0);
    chk("rep.windows", w_idx.size(), 6);
    for (int i = 0; i < 6 && i < w_idx.size(); i++)
      chk($sformatf("rep.idx%0d", i), w_idx[i], exp_idx6[i]);
    foreach (g_len[i]) chk($sformatf("rep.gap_len%0d", i), g_len[i], 3);
    chk("rep.done_count", done_cnt, 0);
    chk("rep.busy_low", int'(busy_low_seen), 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("rep.abort_busy", int'(busy_o), 0);
    chk("rep.abort_idx", int'(idx_o), 0);
    chk("rep.abort_te", int'(te_o), 0);
    chk("rep.abort_done", int'(done_o), 0);

    // Single-message configuration: show, then finish without a gap
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    chk("one.show_te", int'(te1_o), 1);
    chk("one.show_idx", int'(idx1_o), 0);
    chk("one.show_busy", int'(busy1_o), 1);
    @(negedge clk); start1 = 1'b0; tend1 = 1'b1;
    @(posedge clk); #1;
    chk("one.fin_te", int'(te1_o), 0);
    chk("one.fin_done", int'(done1_o), 1);
    chk("one.fin_busy", int'(busy1_o), 1);
    @(negedge clk); tend1 = 1'b0;
    @(posedge clk); #1;
    chk("one.idle_done", int'(done1_o), 0);
    chk("one.idle_busy", int'(busy1_o), 0);
    chk("one.idle_idx", int'(idx1_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
